// File: rtl/lv_wdg_mch_ctrl.sv
// Multi-channel watchdog controller. Each channel runs its own refresh/response FSM,
// and one round-robin arbiter shares a single OWT transmit request between the channels.
module lv_wdg_mch_ctrl #(
    parameter int   CH_NUM    = 4,
    parameter int   CNT_W     = 16,
    parameter int   RETRY_MAX = 2,
    localparam int  CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [CH_NUM-1:0] i_ch_en,
    input  logic [CH_NUM-1:0] i_force_req,
    input  logic [CNT_W-1:0]  i_refresh_th,
    input  logic [CNT_W-1:0]  i_timeout_th,
    output logic              o_tx_req,
    output logic [CH_W-1:0]   o_tx_ch,
    input  logic              i_tx_ack,
    input  logic              i_rx_rsp,
    input  logic [CH_W-1:0]   i_rx_ch,
    output logic [CH_NUM-1:0] o_timeout_err,
    output logic [CH_NUM-1:0] o_fatal_err,
    output logic              o_busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_WAIT, ST_FATAL} ch_state_t;

    ch_state_t          state_q [CH_NUM];
    ch_state_t          state_d [CH_NUM];
    logic [CNT_W-1:0]   cnt_q   [CH_NUM];
    logic [CNT_W-1:0]   cnt_d   [CH_NUM];
    logic [2:0]         retry_q [CH_NUM];
    logic [2:0]         retry_d [CH_NUM];

    logic [CH_NUM-1:0]   force_q;
    logic [CH_NUM-1:0]   force_rise;
    logic [CH_NUM-1:0]   timeout_d;
    logic [CH_NUM-1:0]   timeout_q;
    logic [CH_NUM-1:0]   pend;
    logic [CH_NUM-1:0]   busy_d;
    logic [CH_NUM-1:0]   fatal;
    logic [2*CH_NUM-1:0] pend_rot;
    logic                busy_q;
    logic                tx_req_q;
    logic [CH_W-1:0]     tx_ch_q;
    logic [CH_W-1:0]     rr_ptr_q;
    logic                ack_fire;
    logic                grant_valid;
    logic [CH_W-1:0]     grant_ch;
    logic [CNT_W-1:0]    refresh_lim;
    logic [CNT_W-1:0]    timeout_lim;
    int                  grant_idx;

    // A threshold of 0 behaves like 1; the >= compare keeps counters from ever overflowing.
    assign refresh_lim = (i_refresh_th == '0) ? '0 : i_refresh_th - CNT_W'(1);
    assign timeout_lim = (i_timeout_th == '0) ? '0 : i_timeout_th - CNT_W'(1);

    assign force_rise = i_force_req & ~force_q;
    assign ack_fire   = tx_req_q && i_tx_ack && i_ch_en[tx_ch_q];

    // NOTE: every variable gets a default at the top of the block so no path infers a latch.
    always_comb begin
        for (int k = 0; k < CH_NUM; k++) begin
            state_d[k]   = state_q[k];
            cnt_d[k]     = cnt_q[k];
            retry_d[k]   = retry_q[k];
            timeout_d[k] = 1'b0;
            if (!i_ch_en[k]) begin
                state_d[k] = ST_IDLE;
                cnt_d[k]   = '0;
                retry_d[k] = '0;
            end else begin
                case (state_q[k])
                    ST_IDLE: begin
                        if (force_rise[k] || (cnt_q[k] >= refresh_lim)) begin
                            state_d[k] = ST_PEND;
                            cnt_d[k]   = '0;
                            retry_d[k] = '0;
                        end else begin
                            cnt_d[k] = cnt_q[k] + CNT_W'(1);
                        end
                    end
                    ST_PEND: begin
                        if (ack_fire && (tx_ch_q == CH_W'(k))) begin
                            state_d[k] = ST_WAIT;
                            cnt_d[k]   = '0;
                        end
                    end
                    ST_WAIT: begin
                        // A response arriving on the timeout cycle wins over the timeout.
                        if (i_rx_rsp && (i_rx_ch == CH_W'(k))) begin
                            state_d[k] = ST_IDLE;
                            cnt_d[k]   = '0;
                            retry_d[k] = '0;
                        end else if (cnt_q[k] >= timeout_lim) begin
                            timeout_d[k] = 1'b1;
                            cnt_d[k]     = '0;
                            if (int'(retry_q[k]) < RETRY_MAX) begin
                                retry_d[k] = retry_q[k] + 3'd1;
                                state_d[k] = ST_PEND;
                            end else begin
                                state_d[k] = ST_FATAL;
                            end
                        end else begin
                            cnt_d[k] = cnt_q[k] + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        pend   = '0;
        fatal  = '0;
        busy_d = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            pend[k]   = i_ch_en[k] && (state_q[k] == ST_PEND);
            fatal[k]  = (state_q[k] == ST_FATAL);
            busy_d[k] = (state_d[k] == ST_PEND) || (state_d[k] == ST_WAIT);
        end
    end

    // Rotate the pending mask so bit 0 is the channel at the round-robin pointer.
    always_comb begin
        pend_rot    = {pend, pend} >> rr_ptr_q;
        grant_valid = 1'b0;
        grant_ch    = '0;
        grant_idx   = 0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (!grant_valid && pend_rot[i]) begin
                grant_valid = 1'b1;
                grant_idx   = int'(rr_ptr_q) + i;
                if (grant_idx >= CH_NUM) begin
                    grant_idx = grant_idx - CH_NUM;
                end
                grant_ch = CH_W'(grant_idx);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the per-channel arrays are control state, not storage, so each entry is reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < CH_NUM; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
                retry_q[k] <= '0;
            end
            force_q   <= '0;
            timeout_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                retry_q[k] <= retry_d[k];
            end
            force_q   <= i_force_req;
            timeout_q <= timeout_d;
            busy_q    <= |busy_d;
        end
    end

    // An outstanding request is frozen until acked, or dropped if its channel is disabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_req_q <= 1'b0;
            tx_ch_q  <= '0;
            rr_ptr_q <= '0;
        end else if (tx_req_q) begin
            if (!i_ch_en[tx_ch_q]) begin
                tx_req_q <= 1'b0;
            end else if (i_tx_ack) begin
                tx_req_q <= 1'b0;
                rr_ptr_q <= (tx_ch_q == CH_W'(CH_NUM - 1)) ? '0 : tx_ch_q + CH_W'(1);
            end
        end else if (grant_valid) begin
            tx_req_q <= 1'b1;
            tx_ch_q  <= grant_ch;
        end
    end

    assign o_tx_req      = tx_req_q;
    assign o_tx_ch       = tx_ch_q;
    assign o_timeout_err = timeout_q;
    assign o_fatal_err   = fatal;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_lv_wdg_mch_ctrl.sv
// Scoreboard bench for lv_wdg_mch_ctrl: the driver pushes model predictions per cycle,
// a separate monitor pops and compares them against the DUT outputs.
module tb_lv_wdg_mch_ctrl;

    localparam int CH   = 4;
    localparam int CW   = 16;
    localparam int RMAX = 2;
    localparam int CHW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [CH-1:0]  en;
    logic [CH-1:0]  force_req;
    logic [CW-1:0]  rth;
    logic [CW-1:0]  tth;
    logic           tx_req;
    logic [CHW-1:0] tx_ch;
    logic           tx_ack;
    logic           rx_rsp;
    logic [CHW-1:0] rx_ch;
    logic [CH-1:0]  to_err;
    logic [CH-1:0]  fatal_err;
    logic           busy;

    always #5 clk = ~clk;

    lv_wdg_mch_ctrl #(.CH_NUM(CH), .CNT_W(CW), .RETRY_MAX(RMAX)) dut (
        .i_clk(clk), .i_rst(rst), .i_ch_en(en), .i_force_req(force_req),
        .i_refresh_th(rth), .i_timeout_th(tth), .o_tx_req(tx_req), .o_tx_ch(tx_ch),
        .i_tx_ack(tx_ack), .i_rx_rsp(rx_rsp), .i_rx_ch(rx_ch),
        .o_timeout_err(to_err), .o_fatal_err(fatal_err), .o_busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model (cycle-level, phase + elapsed time per channel)
    typedef enum int {P_IDLE, P_PEND, P_WAIT, P_FATAL} phase_e;
    typedef struct { int cyc; logic [11:0] vec; } exp_t;
    typedef struct { int due; int ch; } rsp_t;

    phase_e        m_ph    [CH];
    int            m_age   [CH];
    int            m_retry [CH];
    bit [CH-1:0]   m_fprev;
    bit            m_req;
    int            m_ch;
    int            m_ptr;
    bit [CH-1:0]   m_to;
    exp_t          exp_q [$];
    rsp_t          rsp_q [$];
    int            cyc = 0;

    task automatic model_step();
        phase_e      nph [CH];
        int          nage [CH];
        int          nret [CH];
        bit [CH-1:0] nto;
        bit [CH-1:0] mfatal;
        bit          nreq, ack_ok, found, mbusy;
        int          nch, nptr, per_r, per_t, c;
        exp_t        e;
        per_r = (rth == 0) ? 1 : int'(rth);
        per_t = (tth == 0) ? 1 : int'(tth);
        nto   = '0;
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                nph[k] = P_IDLE; nage[k] = 0; nret[k] = 0;
            end
            m_fprev = '0; nreq = 0; nch = 0; nptr = 0;
        end else begin
            ack_ok = m_req && tx_ack && en[m_ch];
            for (int k = 0; k < CH; k++) begin
                nph[k] = m_ph[k]; nage[k] = m_age[k]; nret[k] = m_retry[k];
                if (!en[k]) begin
                    nph[k] = P_IDLE; nage[k] = 0; nret[k] = 0;
                end else if (m_ph[k] == P_IDLE) begin
                    if ((force_req[k] && !m_fprev[k]) || (m_age[k] + 1 >= per_r)) begin
                        nph[k] = P_PEND; nage[k] = 0; nret[k] = 0;
                    end else nage[k] = m_age[k] + 1;
                end else if (m_ph[k] == P_PEND) begin
                    if (ack_ok && m_ch == k) begin nph[k] = P_WAIT; nage[k] = 0; end
                end else if (m_ph[k] == P_WAIT) begin
                    if (rx_rsp && int'(rx_ch) == k) begin
                        nph[k] = P_IDLE; nage[k] = 0; nret[k] = 0;
                    end else if (m_age[k] + 1 >= per_t) begin
                        nto[k] = 1; nage[k] = 0;
                        if (m_retry[k] < RMAX) begin nret[k] = m_retry[k] + 1; nph[k] = P_PEND; end
                        else nph[k] = P_FATAL;
                    end else nage[k] = m_age[k] + 1;
                end
            end
            m_fprev = force_req;
            nreq = m_req; nch = m_ch; nptr = m_ptr;
            if (m_req) begin
                if (!en[m_ch]) nreq = 0;
                else if (tx_ack) begin nreq = 0; nptr = (m_ch + 1) % CH; end
            end else begin
                found = 0;
                for (int i = 0; i < CH; i++) begin
                    c = (m_ptr + i) % CH;
                    if (!found && m_ph[c] == P_PEND && en[c]) begin found = 1; nreq = 1; nch = c; end
                end
            end
        end
        mbusy = 0; mfatal = '0;
        for (int k = 0; k < CH; k++) begin
            m_ph[k] = nph[k]; m_age[k] = nage[k]; m_retry[k] = nret[k];
            if (nph[k] == P_PEND || nph[k] == P_WAIT) mbusy = 1;
            mfatal[k] = (nph[k] == P_FATAL);
        end
        m_req = nreq; m_ch = nch; m_ptr = nptr; m_to = nto;
        e.cyc = cyc;
        e.vec = {m_req, CHW'(m_ch), m_to, mfatal, mbusy};
        exp_q.push_back(e);
    endtask

    // ---------------- driver
    bit          ack_rand = 0;
    bit          rsp_rand = 0;
    bit [CH-1:0] ack_mask = '1;
    int          rsp_delay = 0;

    task automatic cycle();
        cyc++;
        if (!ack_rand) tx_ack = m_req && ack_mask[m_ch];
        if (!rsp_rand) begin
            rx_rsp = 1'b0;
            rx_ch  = '0;
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                rx_rsp = 1'b1;
                rx_ch  = CHW'(rsp_q[0].ch);
                rsp_q.delete(0);
            end
            if (rsp_delay > 0 && !rst && m_req && tx_ack && en[m_ch])
                rsp_q.push_back('{cyc + rsp_delay, m_ch});
        end
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        rsp_q.delete();
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    // ---------------- monitor
    int obs_to = 0;
    int obs_rises = 0;
    int first_req_cyc = -1;
    int rel_cyc = 0;
    int grants [$];

    task automatic clear_obs();
        obs_to = 0; obs_rises = 0; first_req_cyc = -1; rel_cyc = cyc + 1;
        grants.delete();
    endtask

    initial begin
        exp_t        e;
        logic [11:0] act;
        bit          prev_req = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {tx_req, tx_ch, to_err, fatal_err, busy};
                check($sformatf("outputs_cyc%0d", e.cyc), {20'd0, act}, {20'd0, e.vec});
                if (tx_req === 1'b1 && !prev_req) begin
                    obs_rises++;
                    grants.push_back(int'(tx_ch));
                    if (first_req_cyc < 0) first_req_cyc = e.cyc;
                end
                prev_req = (tx_req === 1'b1);
                for (int k = 0; k < CH; k++) if (to_err[k] === 1'b1) obs_to++;
            end
        end
    end

    // ---------------- scenarios
    int order_a [4];
    int order_b [4];

    initial begin
        order_a[0] = 0; order_a[1] = 1; order_a[2] = 2; order_a[3] = 3;
        order_b[0] = 1; order_b[1] = 2; order_b[2] = 3; order_b[3] = 0;
        rst = 1'b1; en = '0; force_req = '0; rth = 16'd10; tth = 16'd20;
        tx_ack = 1'b0; rx_rsp = 1'b0; rx_ch = '0;
        @(negedge clk);
        #1;

        // Single channel refresh with a response 3 cycles after the ack.
        rsp_delay = 3; do_reset(3);
        en = 4'b0001; clear_obs();
        repeat (40) cycle();
        check("s1_first_req_edge", first_req_cyc - rel_cyc + 1, 11);
        check("s1_first_ch", (grants.size() > 0) ? grants[0] : -1, 0);
        check("s1_timeouts", obs_to, 0);

        // Round-robin order with forced requests.
        rth = 16'd1000; tth = 16'd50; do_reset(2);
        en = 4'hF; force_req = 4'hF; clear_obs(); cycle(); force_req = '0;
        repeat (20) cycle();
        check("s2_round1_count", grants.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("s2_round1_grant%0d", i), (grants.size() > i) ? grants[i] : -1, order_a[i]);
        clear_obs(); force_req = 4'b0001; cycle(); force_req = '0;
        repeat (10) cycle();
        check("s2_solo_grant", (grants.size() == 1) ? grants[0] : -1, 0);
        clear_obs(); force_req = 4'hF; cycle(); force_req = '0;
        repeat (20) cycle();
        check("s2_round2_count", grants.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("s2_round2_grant%0d", i), (grants.size() > i) ? grants[i] : -1, order_b[i]);

        // Retries exhausted, fatal sticky, cleared by disable.
        rth = 16'd6; tth = 16'd5; rsp_delay = 0; do_reset(2);
        en = 4'b0100; clear_obs();
        repeat (80) cycle();
        check("s3_timeout_pulses", obs_to, 3);
        check("s3_tx_requests", obs_rises, 3);
        check("s3_fatal_sticky", fatal_err, 4'b0100);
        en = '0; cycle();
        check("s3_fatal_cleared", fatal_err, 4'b0000);

        // Response on the exact timeout cycle wins.
        rsp_delay = 5; do_reset(2);
        en = 4'b0001; clear_obs();
        repeat (40) cycle();
        check("s4_no_timeout", obs_to, 0);
        check("s4_refreshed_again", obs_rises >= 3, 1);

        // Reset while a request is outstanding and another channel waits.
        rth = 16'd10; tth = 16'd50; rsp_delay = 0; ack_mask = 4'b0001; do_reset(2);
        en = 4'b0011; force_req = 4'b0011; clear_obs(); cycle(); force_req = '0;
        repeat (5) cycle();
        check("s5_req_outstanding", {tx_req, tx_ch, busy}, {1'b1, 2'd1, 1'b1});
        rst = 1'b1; cycle(); rst = 1'b0;
        check("s5_outputs_in_reset", {tx_req, tx_ch, to_err, fatal_err, busy}, 12'd0);
        ack_mask = '1; clear_obs();
        repeat (20) cycle();
        check("s5_first_req_edge", first_req_cyc - rel_cyc + 1, 11);

        // Disable the granted channel before it is acked.
        rth = 16'd1000; ack_mask = '0; do_reset(2);
        en = 4'b0011; force_req = 4'b0011; clear_obs(); cycle(); force_req = '0; cycle();
        check("s6_granted_ch0", {tx_req, tx_ch}, {1'b1, 2'd0});
        en = 4'b0010; cycle();
        check("s6_req_dropped", tx_req, 1'b0);
        cycle();
        check("s6_regrant_ch1", {tx_req, tx_ch}, {1'b1, 2'd1});

        // Randomized traffic against the model.
        ack_mask = '1; ack_rand = 1; rsp_rand = 1;
        rth = 16'($urandom_range(0, 12)); tth = 16'($urandom_range(0, 8));
        do_reset(2);
        en = 4'hF;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 99) < 3) en = 4'($urandom) | 4'($urandom);
            for (int k = 0; k < CH; k++) force_req[k] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) < 3) rth = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 99) < 3) tth = 16'($urandom_range(0, 8));
            tx_ack = ($urandom_range(0, 1) == 1);
            rx_rsp = ($urandom_range(0, 3) == 0);
            rx_ch  = CHW'($urandom_range(0, 3));
            rst    = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
